// File: rtl/writeback.sv
// Writeback stage: accepts one retired instruction per handshake, selects and
// extends the register-file write data, and keeps a sticky illegal-instruction
// flag plus a retired-instruction counter.
module writeback #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IR,
    input  logic [XLEN-1:0]  RD,
    input  logic [XLEN-1:0]  A,
    input  logic [XLEN-1:0]  PC,
    input  logic             v_in,
    input  logic             stall,
    output logic             r_out,
    output logic             WE,
    output logic [4:0]       WA,
    output logic [XLEN-1:0]  WD,
    output logic             err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    logic            w_accept;
    logic            w_writes;
    logic            w_illegal;
    logic [XLEN-1:0] w_wd;

    assign w_opcode = IR[6:0];
    assign w_funct3 = IR[14:12];
    assign w_rd     = IR[11:7];

    // A registered ready means a stall cycle blocks acceptance for one extra
    // cycle after it, keeping the ready path out of the combinational loop.
    assign w_accept = v_in & r_out & ~stall;

    // Decode the accepted instruction into write intent, data and legality.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statements can infer a latch.
        w_writes  = 1'b0;
        w_illegal = 1'b0;
        w_wd      = '0;
        unique case (w_opcode)
            OPC_LOAD: begin
                w_writes = 1'b1;
                unique case (w_funct3)
                    3'b000:  w_wd = {{(XLEN-8){RD[7]}}, RD[7:0]};
                    3'b001:  w_wd = {{(XLEN-16){RD[15]}}, RD[15:0]};
                    3'b010:  w_wd = RD;
                    3'b100:  w_wd = {{(XLEN-8){1'b0}}, RD[7:0]};
                    3'b101:  w_wd = {{(XLEN-16){1'b0}}, RD[15:0]};
                    default: begin
                        w_writes  = 1'b0;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                w_writes = 1'b1;
                w_wd     = A;
            end
            OPC_JAL, OPC_JALR: begin
                w_writes = 1'b1;
                w_wd     = PC + XLEN'(4);
            end
            OPC_STORE, OPC_BRANCH, OPC_SYSTEM: begin
                w_writes = 1'b0;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Handshake, register-file write port, sticky error and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= 1'b1;
            WE      <= 1'b0;
            WA      <= '0;
            WD      <= '0;
            err     <= 1'b0;
            instret <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_out <= ~stall;
            WE    <= 1'b0;
            if (w_accept) begin
                WE      <= w_writes & (w_rd != 5'd0);
                WA      <= w_rd;
                WD      <= w_wd;
                instret <= instret + CNT_W'(1);
                if (w_illegal) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback.sv
// Directed bench for the writeback stage with a scoreboard of expected writes.
module tb_writeback;

    localparam int XLEN   = 32;
    localparam int CNT_W  = 64;
    localparam int CNT_WS = 4;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       IR, RD, A, PC;
    logic              v_in, stall;
    logic              r_out, WE, err;
    logic [4:0]        WA;
    logic [31:0]       WD;
    logic [CNT_W-1:0]  instret;

    // Narrow-counter copy sharing the same stimulus, used to reach wrap.
    logic              s_r_out, s_we, s_err;
    logic [4:0]        s_wa;
    logic [31:0]       s_wd;
    logic [CNT_WS-1:0] s_instret;

    int checks = 0;
    int errors = 0;

    exp_t              sb[$];
    logic [CNT_W-1:0]  exp_cnt;
    logic              exp_err;

    writeback #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .IR(IR), .RD(RD), .A(A), .PC(PC),
        .v_in(v_in), .stall(stall), .r_out(r_out), .WE(WE), .WA(WA),
        .WD(WD), .err(err), .instret(instret)
    );

    writeback #(.XLEN(XLEN), .CNT_W(CNT_WS)) dut_s (
        .clk(clk), .rst(rst), .IR(IR), .RD(RD), .A(A), .PC(PC),
        .v_in(v_in), .stall(stall), .r_out(s_r_out), .WE(s_we), .WA(s_wa),
        .WD(s_wd), .err(s_err), .instret(s_instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
        return {17'd0, f3, rd, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_we"}, 64'(WE), 64'd0);
        check({tag, "_wa"}, 64'(WA), 64'd0);
        check({tag, "_wd"}, 64'(WD), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_instret"}, instret, 64'd0);
        check({tag, "_rout"}, 64'(r_out), 64'd1);
    endtask

    // Pulse reset across one edge; model state returns to zero.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_idle_zero("rst");
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        exp_err = 1'b0;
        sb.delete();
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_we"}, 64'(WE), 64'(e.we));
            check({tag, "_wa"}, 64'(WA), 64'(e.wa));
            if (e.we) check({tag, "_wd"}, 64'(WD), 64'(e.wd));
        end
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_instret"}, instret, exp_cnt);
        check({tag, "_instret_s"}, 64'(s_instret), 64'(exp_cnt[CNT_WS-1:0]));
    endtask

    // Present one instruction for exactly one accepting edge and check the result.
    task automatic issue(input string tag, input logic [31:0] ir, input logic [31:0] rd,
                         input logic [31:0] a, input logic [31:0] pc,
                         input logic exp_we, input logic [31:0] exp_wd, input logic exp_ill);
        exp_t e;
        IR = ir; RD = rd; A = a; PC = pc; v_in = 1'b1;
        e.we = exp_we; e.wa = ir[11:7]; e.wd = exp_wd;
        sb.push_back(e);
        exp_cnt = exp_cnt + 1;
        if (exp_ill) exp_err = 1'b1;
        tick();
        v_in = 1'b0;
        compare_out(tag);
    endtask

    initial begin
        rst = 1'b1; v_in = 1'b0; stall = 1'b0;
        IR = '0; RD = '0; A = '0; PC = '0;
        exp_cnt = '0; exp_err = 1'b0;
        #1;
        check_idle_zero("por");
        tick();
        rst = 1'b0;

        // Loads: first accept lands on the first edge after reset release.
        issue("lb",  mk(7'b0000011, 5'd5, 3'b000), 32'h0000_0080, 32'h0, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
        check("lb_instret1", instret, 64'd1);
        issue("lhu", mk(7'b0000011, 5'd7, 3'b101), 32'h0000_F00F, 32'h0, 32'h0, 1'b1, 32'h0000_F00F, 1'b0);
        issue("lh",  mk(7'b0000011, 5'd7, 3'b001), 32'h0000_F00F, 32'h0, 32'h0, 1'b1, 32'hFFFF_F00F, 1'b0);
        issue("lbu", mk(7'b0000011, 5'd8, 3'b100), 32'h1234_56F0, 32'h0, 32'h0, 1'b1, 32'h0000_00F0, 1'b0);
        issue("lw",  mk(7'b0000011, 5'd9, 3'b010), 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // ALU-class results, link addresses and no-write opcodes.
        issue("jal",   mk(7'b1101111, 5'd1, 3'b000), 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 1'b0);
        issue("jalr",  mk(7'b1100111, 5'd2, 3'b000), 32'h0, 32'h0, 32'h0000_1000, 1'b1, 32'h0000_1004, 1'b0);
        issue("op_x0", mk(7'b0110011, 5'd0, 3'b000), 32'h0, 32'h1234, 32'h0, 1'b0, 32'h0, 1'b0);
        issue("lui",   mk(7'b0110111, 5'd10, 3'b000), 32'h0, 32'hABCD_E000, 32'h0, 1'b1, 32'hABCD_E000, 1'b0);
        issue("store", mk(7'b0100011, 5'd11, 3'b010), 32'h0, 32'h5555, 32'h0, 1'b0, 32'h0, 1'b0);
        issue("sys",   mk(7'b1110011, 5'd12, 3'b000), 32'h0, 32'h5555, 32'h0, 1'b0, 32'h0, 1'b0);

        // Back-to-back writes to the same register stay separate pulses.
        issue("b2b_0", mk(7'b0010011, 5'd3, 3'b000), 32'h0, 32'h1, 32'h0, 1'b1, 32'h1, 1'b0);
        issue("b2b_1", mk(7'b0010011, 5'd3, 3'b000), 32'h0, 32'h2, 32'h0, 1'b1, 32'h2, 1'b0);
        tick();
        check("idle_we", 64'(WE), 64'd0);

        // Illegal opcode sets the sticky flag, which survives legal traffic.
        issue("ill_op", mk(7'b1111111, 5'd4, 3'b000), 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            issue("after_ill", mk(7'b0110011, 5'd6, 3'b000), 32'h0, 32'(i), 32'h0, 1'b1, 32'(i), 1'b0);
        end
        do_reset();
        check("err_cleared", 64'(err), 64'd0);
        issue("ill_ld", mk(7'b0000011, 5'd4, 3'b011), 32'hFF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        do_reset();

        // Stall with valid held: three blocked edges, one recovery edge, one accept.
        IR = mk(7'b0110011, 5'd13, 3'b000); RD = '0; A = 32'hCAFE_0001; PC = '0;
        v_in = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_we", 64'(WE), 64'd0);
            check("stall_rout", 64'(r_out), 64'd0);
            check("stall_instret", instret, exp_cnt);
        end
        stall = 1'b0;
        tick();
        check("recover_we", 64'(WE), 64'd0);
        check("recover_rout", 64'(r_out), 64'd1);
        sb.push_back('{we: 1'b1, wa: 5'd13, wd: 32'hCAFE_0001});
        exp_cnt = exp_cnt + 1;
        tick();
        v_in = 1'b0;
        compare_out("stall_accept");
        tick();
        check("stall_single", 64'(WE), 64'd0);
        check("stall_single_cnt", instret, exp_cnt);

        // Narrow counter copy wraps back to zero after 2^CNT_WS accepts.
        do_reset();
        for (int i = 0; i < (1 << CNT_WS) - 1; i++) begin
            issue("fill", mk(7'b0010011, 5'd14, 3'b000), 32'h0, 32'(i), 32'h0, 1'b1, 32'(i), 1'b0);
        end
        check("pre_wrap", 64'(s_instret), 64'((1 << CNT_WS) - 1));
        issue("wrap", mk(7'b0010011, 5'd14, 3'b000), 32'h0, 32'h77, 32'h0, 1'b1, 32'h77, 1'b0);
        check("wrap_zero", 64'(s_instret), 64'd0);
        check("wide_no_wrap", instret, 64'(1 << CNT_WS));

        // Async reset mid-cycle with an instruction in flight.
        issue("pre_rst", mk(7'b0110011, 5'd15, 3'b000), 32'h0, 32'h9999, 32'h0, 1'b1, 32'h9999, 1'b0);
        IR = mk(7'b0110011, 5'd16, 3'b000); A = 32'h4444; v_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_idle_zero("async_rst");
        tick();
        check("inflight_we", 64'(WE), 64'd0);
        check("inflight_cnt", instret, 64'd0);
        v_in = 1'b0;
        rst = 1'b0;
        exp_cnt = '0; exp_err = 1'b0; sb.delete();
        tick();
        check("post_rst_we", 64'(WE), 64'd0);
        check("post_rst_cnt", instret, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- XLEN, 32, datapath width
- CNT_W, 64, retired-instruction counter width
REQ-002 The block SHALL have these ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- IR  in  32  instruction from memory stage
- RD  in  32  raw load data, zero-padded, not yet extended
- A  in  32  ALU result passed through memory stage
- PC  in  32  PC of the instruction
- v_in  in  1  upstream valid
- stall  in  1  hold request from hazard control
- r_out  out  1  ready to upstream
- WE  out  1  register-file write enable, one cycle per write
- WA  out  5  register-file write address
- WD  out  32  register-file write data
- err  out  1  sticky illegal-opcode/funct3 flag
- instret  out  CNT_W  retired-instruction count
REQ-003 Clock and reset SHALL be exactly as decided: one clock clk; rst asynchronous, active-high.

Function
REQ-004 Accept SHALL occur on a rising clk edge when v_in & r_out & !stall; nothing else updates WE, WA, WD, err or instret.
REQ-005 r_out SHALL be registered: r_out <= !stall each edge; r_out is therefore low the cycle after any stall cycle.
REQ-006 WE/WA/WD SHALL be registered, appearing one cycle after accept; WE SHALL be 0 on any edge without accept.
REQ-007 WA SHALL be IR[11:7] of the accepted instruction; WE SHALL be 0 when IR[11:7] = 0.
REQ-008 Data select by IR[6:0]:
- LOAD 0000011: extend RD by IR[14:12]: 000 sign from bit 7, 001 sign from bit 15, 010 pass, 100 zero from bit 7, 101 zero from bit 15
- OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111: WD = A
- JAL 1101111, JALR 1100111: WD = PC + 4, modulo 2^32
- STORE 0100011, BRANCH 1100011, SYSTEM 1110011: WE = 0
REQ-009 Any other opcode, or LOAD with funct3 in {011,110,111}, SHALL give WE = 0 and set err; err stays 1 until reset.
REQ-010 instret SHALL increment by 1 on every accept, including no-write and illegal instructions, and wrap from 2^CNT_W-1 to 0.
REQ-011 When stall and v_in are both high, the instruction SHALL NOT be accepted; upstream holds it (IR/RD/A/PC stable while v_in & !r_out).
REQ-012 Back-to-back accepts to the same WA SHALL each produce their own WE pulse in order, with no merging.

Reset
REQ-013 While rst is high, regardless of clk: WE=0, WA=0, WD=0, err=0, instret=0, r_out=1.
REQ-014 Reset asserted mid-transfer SHALL discard the in-flight instruction: no WE pulse and no instret increment for it.
REQ-015 The first accept SHALL be possible on the first rising edge after rst falls.

Verification
REQ-016 Bench SHALL cover these scenarios:
- LOAD funct3=000, RD=0x00000080, rd=5 -> next cycle WE=1, WA=5, WD=0xFFFFFF80; instret=1
- LOAD funct3=101, RD=0x0000F00F, rd=7 -> WD=0x0000F00F; funct3=001 same RD -> WD=0xFFFFF00F
- JAL PC=0xFFFFFFFC, rd=1 -> WD=0x00000000; OP with rd=0, A=0x1234 -> WE=0, instret still increments
- opcode 0x7F accepted -> WE=0, err=1 held across 10 further legal instructions; rst pulse -> err=0
- stall high 3 cycles with v_in=1 -> no WE pulse, r_out=0 from the 2nd edge; stall released -> exactly one write after r_out returns to 1
- instret preset near wrap (force 0xFFFF_FFFF_FFFF_FFFF) plus one accept -> instret=0; async rst mid-cycle -> outputs zero before the next edge
